imem_fetch_port: RTL and testbench
==================================

# imem_fetch_port

Parametrised, synchronous-read instruction memory for the fetch stage, replacing the combinational word-array lookup. Word-organised, byte-addressed storage with a valid/ready request channel from the PC logic and a valid/ready response channel to decode. It also has a program-load write port, alignment and range fault reporting, and a flush input for branch redirects. It sits between the PC register and the decode stage and maps onto one single-port block RAM.

## Interface
- XLEN, 32, width of fetch and load addresses
- DEPTH, 512, number of 32-bit words; power of two, ≥ 2
- INIT_WORDS, 0, number of low words cleared by the simulation initial block; content is not cleared by reset
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  fetch request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_addr  in  XLEN  byte address of instruction
- resp_valid  out  1  response held in output register
- resp_ready  in  1  decode consumes response
- resp_data  out  32  instruction word
- resp_fault  out  2  00 ok, 01 misaligned, 10 out of range
- flush  in  1  discard held response (redirect)
- ld_we  in  1  program-load write strobe
- ld_addr  in  XLEN  byte address of word to write (bits [1:0] ignored)
- ld_data  in  32  word to write

## Operation
- Word index is addr[log2(DEPTH)+1:2].
- Misaligned means addr[1:0] != 0. Out of range means addr[XLEN-1:log2(DEPTH)+2] != 0. Misaligned takes priority when both apply.
- A faulted request is still accepted. Its response carries resp_data = 32'h0000_0013 (NOP) and the fault code. No RAM read contributes to it.
- req_ready = !ld_we && (!resp_valid || resp_ready || flush). Load writes have strict priority over fetches on the single RAM port.
- On acceptance, the RAM is read and the output register loads data and fault. resp_valid is set.
- resp_valid clears when resp_ready is high and no new request is accepted, or when flush is high and no new request is accepted.
- flush with an accepted request in the same cycle: the old response is dropped and the new response appears next cycle. This is the normal redirect path.
- ld_we with an in-range ld_addr writes ld_data to the RAM next edge. An out-of-range ld_addr is silently dropped. A held response is never altered by a later write.
- The output register holds stable while resp_valid && !resp_ready && !flush.

## Timing
- Reset values: resp_valid=0, resp_data=0, resp_fault=00. req_ready is 0 during the rst cycle.
- rst mid-operation drops any held response. RAM contents are retained.
- Latency: request accepted on edge N gives resp_valid=1 with data after edge N (visible in cycle N+1).
- Throughput: 1 word/cycle when resp_ready is held high and ld_we is low.
- Back-to-back: accept plus consume in the same cycle refills the register with no bubble.
- Load then fetch of the same word on consecutive cycles returns the newly written data (write edge N, read edge N+1).
- A load write and a request in the same cycle: the request is not accepted, and the PC side must hold req_addr.

## Structure
- Package imem_pkg holds:
  - FAULT_NONE/FAULT_MISALIGN/FAULT_RANGE localparams
  - the NOP_INSN constant
  - a function computing the word-index width from DEPTH
- Sub-module imem_bram: single-port RAM, synchronous read, write-first, (* syn_ramstyle = "block_ram" *). Ports are clk, en, we, addr, wdata, rdata.
- imem_fetch_port owns the arbitration, the fault decode and the output valid/data/fault register.

## Test plan
- Load 0xfff00093, 0x00400113 to words 0,1; fetch 0x0 then 0x4 with resp_ready=1 -> responses 0xfff00093, 0x00400113 in consecutive cycles, fault 00.
- Fetch 0x2 -> resp_data=0x00000013, resp_fault=01; fetch DEPTH*4 -> 0x00000013, fault 10.
- Hold resp_ready=0 for 3 cycles after fetching 0x0 -> resp_data stable and req_ready=0; then resp_ready=1 with new request 0x4 -> next word with no bubble.
- Response pending with resp_ready=0; assert flush with request 0x8 -> old response dropped, next cycle word 2 returned.
- ld_we=1 with req_valid=1 at 0x0 -> req_ready=0 and the write lands; next cycle the request is accepted and returns the new data.
- Assert rst while resp_valid=1 -> resp_valid=0 and resp_fault=00 next cycle; a later fetch of 0x0 returns the pre-reset RAM content.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and helpers for the instruction-memory fetch port.
package imem_pkg;

  // Fault codes reported alongside every fetch response
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  // addi x0, x0, 0 -- returned in place of RAM data for faulted fetches
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Number of word-index bits needed to address a memory of the given depth
  function automatic int unsigned word_index_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_bram.sv
// Single-port block RAM with synchronous, write-first read.
module imem_bram
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = word_index_width(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  (* syn_ramstyle = "block_ram" *) logic [31:0] mem [DEPTH];

  // One access per cycle: a write also forwards its data to the read port
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata     <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/imem_fetch_port.sv
// Fetch-side port of the instruction memory: arbitration between program
// load and fetch, fault decode, and the valid/ready response register.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned INIT_WORDS = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_data,
  output logic [1:0]      resp_fault,
  input  logic            flush,
  input  logic            ld_we,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [31:0]     ld_data
);

  localparam int unsigned AW = word_index_width(DEPTH);

  // Power-up clearing of the low words belongs to the memory init flow, not
  // to this logic; the parameter is carried so callers keep one interface.
  localparam int unsigned unused_init_words = INIT_WORDS;

  logic          unused_ld_bits;
  logic          misalign;
  logic          out_of_range;
  logic [1:0]    req_fault;
  logic          accept;
  logic          ld_in_range;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;
  logic          fresh;
  logic [31:0]   hold_data;

  assign unused_ld_bits = ^ld_addr[1:0];

  // Fault decode of the request address; misalignment wins over range
  always_comb begin
    misalign     = (req_addr[1:0] != 2'b00);
    out_of_range = (req_addr[XLEN-1:AW+2] != '0);
    req_fault    = FAULT_NONE;
    if (misalign)          req_fault = FAULT_MISALIGN;
    else if (out_of_range) req_fault = FAULT_RANGE;
  end

  // Port arbitration: loads own the RAM, fetches go when the output slot frees
  always_comb begin
    req_ready   = !rst && !ld_we && (!resp_valid || resp_ready || flush);
    accept      = req_valid && req_ready;
    ld_in_range = (ld_addr[XLEN-1:AW+2] == '0);
    ram_we      = ld_we && ld_in_range;
    ram_en      = ram_we || (accept && (req_fault == FAULT_NONE));
    ram_addr    = ld_we ? ld_addr[AW+1:2] : req_addr[AW+1:2];
  end

  imem_bram #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) u_bram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ld_data),
    .rdata (ram_rdata)
  );

  // The RAM output is only trusted the cycle after a good read; after that
  // the word lives in hold_data so later load writes cannot disturb it
  assign resp_data = fresh ? ram_rdata : hold_data;

  // Response register: valid flag, fault code and the data capture stage
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_fault <= FAULT_NONE;
      fresh      <= 1'b0;
      hold_data  <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_fault <= req_fault;
      fresh      <= (req_fault == FAULT_NONE);
      hold_data  <= NOP_INSN;
    end else begin
      fresh     <= 1'b0;
      hold_data <= resp_data;
      if (resp_valid && (resp_ready || flush)) resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed self-checking bench for imem_fetch_port.
module tb_imem_fetch_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_fault;
  logic        flush;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  int vec_count = 0;
  int err_count = 0;

  imem_fetch_port #(.XLEN(32), .DEPTH(512), .INIT_WORDS(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_fault (resp_fault),
    .flush      (flush),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Advance past the next rising edge so registered outputs have settled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_addr = 32'h0; resp_ready = 1'b1;
    flush = 1'b0; ld_we = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
    tick(); tick();
    vec_count++; if (resp_valid !== 1'b0) begin err_count++; $display("[TB] FAIL reset_valid got %b want 0", resp_valid); end
    vec_count++; if (resp_data !== 32'h0) begin err_count++; $display("[TB] FAIL reset_data got %h want 00000000", resp_data); end
    vec_count++; if (resp_fault !== 2'b00) begin err_count++; $display("[TB] FAIL reset_fault got %b want 00", resp_fault); end
    vec_count++; if (req_ready !== 1'b0) begin err_count++; $display("[TB] FAIL reset_ready got %b want 0", req_ready); end
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    vec_count++; if (req_ready !== 1'b1) begin err_count++; $display("[TB] FAIL post_reset_ready got %b want 1", req_ready); end
  endtask

  task automatic test_fetch_basic();
    load_word(32'h0, 32'hfff00093);
    load_word(32'h4, 32'h00400113);
    load_word(32'h8, 32'h00800193);
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    tick();
    vec_count++; if (resp_valid !== 1'b1 || resp_data !== 32'hfff00093 || resp_fault !== 2'b00) begin err_count++; $display("[TB] FAIL basic_w0 got v=%b d=%h f=%b want v=1 d=fff00093 f=00", resp_valid, resp_data, resp_fault); end
    req_addr = 32'h4;
    tick();
    vec_count++; if (resp_valid !== 1'b1 || resp_data !== 32'h00400113 || resp_fault !== 2'b00) begin err_count++; $display("[TB] FAIL basic_w1 got v=%b d=%h f=%b want v=1 d=00400113 f=00", resp_valid, resp_data, resp_fault); end
    req_valid = 1'b0;
    tick();
    vec_count++; if (resp_valid !== 1'b0) begin err_count++; $display("[TB] FAIL basic_drain got %b want 0", resp_valid); end
  endtask

  task automatic test_faults();
    logic [31:0] addrs [3];
    logic [1:0]  faults [3];
    addrs[0] = 32'h2;   faults[0] = 2'b01;
    addrs[1] = 32'h800; faults[1] = 2'b10;
    addrs[2] = 32'h802; faults[2] = 2'b01;
    resp_ready = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = addrs[i];
      tick();
      vec_count++; if (resp_valid !== 1'b1 || resp_data !== 32'h00000013 || resp_fault !== faults[i]) begin err_count++; $display("[TB] FAIL fault_%0d got v=%b d=%h f=%b want v=1 d=00000013 f=%b", i, resp_valid, resp_data, resp_fault, faults[i]); end
    end
    req_valid = 1'b0;
    tick();
    vec_count++; if (resp_valid !== 1'b0) begin err_count++; $display("[TB] FAIL fault_drain got %b want 0", resp_valid); end
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    tick();
    vec_count++; if (resp_valid !== 1'b1 || resp_data !== 32'hfff00093) begin err_count++; $display("[TB] FAIL bp_first got v=%b d=%h want v=1 d=fff00093", resp_valid, resp_data); end
    req_addr = 32'h4;
    #1;
    vec_count++; if (req_ready !== 1'b0) begin err_count++; $display("[TB] FAIL bp_ready_low got %b want 0", req_ready); end
    for (int i = 0; i < 3; i++) begin
      ld_we = (i == 0); ld_addr = 32'h14; ld_data = 32'hdeadbeef;
      tick();
      ld_we = 1'b0;
      vec_count++; if (resp_valid !== 1'b1 || resp_data !== 32'hfff00093 || req_ready !== 1'b0) begin err_count++; $display("[TB] FAIL bp_hold_%0d got v=%b d=%h rdy=%b want v=1 d=fff00093 rdy=0", i, resp_valid, resp_data, req_ready); end
    end
    resp_ready = 1'b1;
    #1;
    vec_count++; if (req_ready !== 1'b1) begin err_count++; $display("[TB] FAIL bp_release_ready got %b want 1", req_ready); end
    tick();
    vec_count++; if (resp_valid !== 1'b1 || resp_data !== 32'h00400113) begin err_count++; $display("[TB] FAIL bp_next got v=%b d=%h want v=1 d=00400113", resp_valid, resp_data); end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] words [4];
    addrs[0] = 32'h0;  words[0] = 32'hfff00093;
    addrs[1] = 32'h4;  words[1] = 32'h00400113;
    addrs[2] = 32'h8;  words[2] = 32'h00800193;
    addrs[3] = 32'h14; words[3] = 32'hdeadbeef;
    resp_ready = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = addrs[i];
      tick();
      vec_count++; if (resp_valid !== 1'b1 || resp_data !== words[i]) begin err_count++; $display("[TB] FAIL b2b_%0d got v=%b d=%h want v=1 d=%h", i, resp_valid, resp_data, words[i]); end
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
    tick();
    vec_count++; if (resp_valid !== 1'b1 || resp_data !== 32'h00400113) begin err_count++; $display("[TB] FAIL flush_pending got v=%b d=%h want v=1 d=00400113", resp_valid, resp_data); end
    flush = 1'b1; req_addr = 32'h8;
    #1;
    vec_count++; if (req_ready !== 1'b1) begin err_count++; $display("[TB] FAIL flush_ready got %b want 1", req_ready); end
    tick();
    flush = 1'b0; req_valid = 1'b0;
    vec_count++; if (resp_valid !== 1'b1 || resp_data !== 32'h00800193 || resp_fault !== 2'b00) begin err_count++; $display("[TB] FAIL flush_redirect got v=%b d=%h f=%b want v=1 d=00800193 f=00", resp_valid, resp_data, resp_fault); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vec_count++; if (resp_valid !== 1'b0) begin err_count++; $display("[TB] FAIL flush_drop got %b want 0", resp_valid); end
  endtask

  task automatic test_load_collision();
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    ld_we = 1'b1; ld_addr = 32'h0; ld_data = 32'h00a00213;
    #1;
    vec_count++; if (req_ready !== 1'b0) begin err_count++; $display("[TB] FAIL coll_ready got %b want 0", req_ready); end
    tick();
    ld_we = 1'b0;
    vec_count++; if (resp_valid !== 1'b0) begin err_count++; $display("[TB] FAIL coll_no_accept got %b want 0", resp_valid); end
    tick();
    vec_count++; if (resp_valid !== 1'b1 || resp_data !== 32'h00a00213) begin err_count++; $display("[TB] FAIL coll_new_data got v=%b d=%h want v=1 d=00a00213", resp_valid, resp_data); end
    req_valid = 1'b0;
    tick();
    load_word(32'h800, 32'h11111111);
    req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_valid = 1'b0;
    vec_count++; if (resp_data !== 32'h00a00213 || resp_fault !== 2'b00) begin err_count++; $display("[TB] FAIL oor_load_dropped got d=%h f=%b want d=00a00213 f=00", resp_data, resp_fault); end
    tick();
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h2;
    tick();
    req_valid = 1'b0;
    vec_count++; if (resp_valid !== 1'b1 || resp_fault !== 2'b01) begin err_count++; $display("[TB] FAIL rmid_pending got v=%b f=%b want v=1 f=01", resp_valid, resp_fault); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec_count++; if (resp_valid !== 1'b0 || resp_fault !== 2'b00 || resp_data !== 32'h0) begin err_count++; $display("[TB] FAIL rmid_cleared got v=%b f=%b d=%h want v=0 f=00 d=00000000", resp_valid, resp_fault, resp_data); end
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_valid = 1'b0;
    vec_count++; if (resp_valid !== 1'b1 || resp_data !== 32'h00a00213) begin err_count++; $display("[TB] FAIL rmid_retained got v=%b d=%h want v=1 d=00a00213", resp_valid, resp_data); end
    tick();
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_fetch_basic();
    test_faults();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_load_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
